// File: rtl/alu_seq_hs.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_hs
//  Description : Handshaked ALU with registered, held result. Single-cycle ops
//                complete in one cycle; DIV uses a multi-cycle restoring
//                divider that produces {remainder, quotient}.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_seq_hs #(
    parameter int DATA_W = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [DATA_W-1:0]     A,
    input  logic [DATA_W-1:0]     B,
    input  logic [3:0]            ALU_FUN,
    output logic [2*DATA_W-1:0]   ALU_OUT,
    output logic                  CARRY,
    output logic                  DIV_ZERO,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY
);

    localparam int               RES_W     = 2 * DATA_W;
    localparam int               CNT_W     = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);
    localparam logic [3:0]       OP_DIV    = 4'h3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic              accept;
    logic              div_start;
    logic              div_last;
    logic [RES_W-1:0]  op_result;
    logic              op_carry;
    logic              op_div_zero;
    logic [DATA_W:0]   sum_ext;

    // Divider working registers: div_work starts as the dividend and fills
    // with quotient bits from the LSB as dividend bits leave at the MSB.
    logic [DATA_W-1:0] div_work;
    logic [DATA_W-1:0] div_rem;
    logic [DATA_W-1:0] div_dvs;
    logic [CNT_W-1:0]  div_cnt;
    logic [DATA_W:0]   trial;
    logic              trial_ge;
    logic [DATA_W-1:0] rem_next;
    logic [DATA_W-1:0] work_next;

    assign accept    = IN_VALID & IN_READY;
    assign div_start = (ALU_FUN == OP_DIV) && (B != '0);
    assign div_last  = (div_cnt == LAST_STEP);
    assign sum_ext   = {1'b0, A} + {1'b0, B};

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign trial     = {div_rem, div_work[DATA_W-1]};
    assign trial_ge  = (trial >= {1'b0, div_dvs});
    assign rem_next  = trial_ge ? (trial[DATA_W-1:0] - div_dvs) : trial[DATA_W-1:0];
    assign work_next = {div_work[DATA_W-2:0], trial_ge};

    // Single-cycle operation results; DIV here only covers the B==0 case.
    always_comb begin
        op_result   = '0;
        op_carry    = 1'b0;
        op_div_zero = 1'b0;
        case (ALU_FUN)
            4'h0: begin
                op_result = {{(DATA_W-1){1'b0}}, sum_ext};
                op_carry  = sum_ext[DATA_W];
            end
            4'h1: begin
                op_result = {{DATA_W{1'b0}}, A} - {{DATA_W{1'b0}}, B};
                op_carry  = (A < B);
            end
            4'h2: op_result = {{DATA_W{1'b0}}, A} * {{DATA_W{1'b0}}, B};
            4'h3: begin
                op_result   = {A, {DATA_W{1'b1}}};
                op_div_zero = 1'b1;
            end
            4'h4: op_result = {{DATA_W{1'b0}}, A & B};
            4'h5: op_result = {{DATA_W{1'b0}}, A | B};
            4'h6: op_result = {{DATA_W{1'b0}}, ~(A & B)};
            4'h7: op_result = {{DATA_W{1'b0}}, ~(A | B)};
            4'h8: op_result = {{DATA_W{1'b0}}, A ^ B};
            4'h9: op_result = {{DATA_W{1'b0}}, ~(A ^ B)};
            4'hA: op_result = (A == B) ? RES_W'(1) : '0;
            4'hB: op_result = (A > B)  ? RES_W'(2) : '0;
            4'hC: op_result = (A < B)  ? RES_W'(3) : '0;
            4'hD: op_result = {{(DATA_W+1){1'b0}}, A[DATA_W-1:1]};
            4'hE: op_result = {{(DATA_W-1){1'b0}}, A, 1'b0};
            default: op_result = '0;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake outputs; DONE accepts a new op while draining.
    always_comb begin
        state_next = state;
        OUT_VALID  = (state == ST_DONE);
        IN_READY   = (state != ST_DIV) && (!OUT_VALID || OUT_READY);
        case (state)
            ST_IDLE, ST_DONE: begin
                if (IN_VALID && IN_READY) begin
                    state_next = div_start ? ST_DIV : ST_DONE;
                end else if ((state == ST_DONE) && OUT_READY) begin
                    state_next = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (div_last) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Result registers and divider datapath.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            ALU_OUT  <= '0;
            CARRY    <= 1'b0;
            DIV_ZERO <= 1'b0;
            div_work <= '0;
            div_rem  <= '0;
            div_dvs  <= '0;
            div_cnt  <= '0;
        end else if (accept) begin
            if (div_start) begin
                div_work <= A;
                div_dvs  <= B;
                div_rem  <= '0;
                div_cnt  <= '0;
            end else begin
                ALU_OUT  <= op_result;
                CARRY    <= op_carry;
                DIV_ZERO <= op_div_zero;
            end
        end else if (state == ST_DIV) begin
            div_work <= work_next;
            div_rem  <= rem_next;
            div_cnt  <= div_cnt + CNT_W'(1);
            if (div_last) begin
                ALU_OUT  <= {rem_next, work_next};
                CARRY    <= 1'b0;
                DIV_ZERO <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_hs.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq_hs
//  Description : Scoreboard bench for alu_seq_hs at DATA_W=8 and DATA_W=16.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_seq_hs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;          // 0 drives the 8-bit instance, 1 the 16-bit one
    logic        in_valid;
    logic        out_ready;
    logic [15:0] a_d;
    logic [15:0] b_d;
    logic [3:0]  fun_d;

    logic        ir8, ov8, cy8, dz8;
    logic [15:0] out8;
    logic        ir16, ov16, cy16, dz16;
    logic [31:0] out16;

    logic        ir, ov, cy, dz;
    logic [31:0] out_v;

    typedef struct {
        logic [31:0] out;
        logic        carry;
        logic        dz;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];
    exp_t e8, e16;

    int checks = 0;
    int errors = 0;

    // Free-running clock.
    always #5 clk = ~clk;

    alu_seq_hs #(.DATA_W(8)) dut8 (
        .CLK(clk), .RST(rst_n), .IN_VALID(in_valid & ~sel), .IN_READY(ir8),
        .A(a_d[7:0]), .B(b_d[7:0]), .ALU_FUN(fun_d), .ALU_OUT(out8),
        .CARRY(cy8), .DIV_ZERO(dz8), .OUT_VALID(ov8), .OUT_READY(out_ready)
    );

    alu_seq_hs #(.DATA_W(16)) dut16 (
        .CLK(clk), .RST(rst_n), .IN_VALID(in_valid & sel), .IN_READY(ir16),
        .A(a_d), .B(b_d), .ALU_FUN(fun_d), .ALU_OUT(out16),
        .CARRY(cy16), .DIV_ZERO(dz16), .OUT_VALID(ov16), .OUT_READY(out_ready)
    );

    assign ir    = sel ? ir16 : ir8;
    assign ov    = sel ? ov16 : ov8;
    assign cy    = sel ? cy16 : cy8;
    assign dz    = sel ? dz16 : dz8;
    assign out_v = sel ? out16 : {16'h0000, out8};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Reference model: plain arithmetic on the operation definitions.
    function automatic exp_t model(input int w, input logic [3:0] op,
                                   input logic [63:0] a, input logic [63:0] b);
        logic [63:0] mw, m2, r;
        exp_t e;
        mw = (64'd1 << w) - 64'd1;
        m2 = (64'd1 << (2 * w)) - 64'd1;
        r = 64'd0;
        e.carry = 1'b0;
        e.dz = 1'b0;
        case (op)
            4'h0: begin r = a + b; e.carry = r[w]; end
            4'h1: begin r = (a - b) & m2; e.carry = (a < b); end
            4'h2: r = a * b;
            4'h3: begin
                if (b == 64'd0) begin r = (a << w) | mw; e.dz = 1'b1; end
                else r = ((a % b) << w) | (a / b);
            end
            4'h4: r = a & b;
            4'h5: r = a | b;
            4'h6: r = ~(a & b) & mw;
            4'h7: r = ~(a | b) & mw;
            4'h8: r = a ^ b;
            4'h9: r = ~(a ^ b) & mw;
            4'hA: r = (a == b) ? 64'd1 : 64'd0;
            4'hB: r = (a > b)  ? 64'd2 : 64'd0;
            4'hC: r = (a < b)  ? 64'd3 : 64'd0;
            4'hD: r = a >> 1;
            4'hE: r = a << 1;
            default: r = 64'd0;
        endcase
        e.out = r[31:0];
        return e;
    endfunction

    // Monitor: every completed output transfer is checked against the queue head.
    always @(negedge clk) begin
        if (rst_n && out_ready) begin
            if (ov8) begin
                if (q8.size() == 0) fail("dut8_unexpected_output");
                else begin
                    e8 = q8.pop_front();
                    chk("dut8_out", {16'h0000, out8}, e8.out);
                    chk("dut8_carry", {31'd0, cy8}, {31'd0, e8.carry});
                    chk("dut8_div_zero", {31'd0, dz8}, {31'd0, e8.dz});
                end
            end
            if (ov16) begin
                if (q16.size() == 0) fail("dut16_unexpected_output");
                else begin
                    e16 = q16.pop_front();
                    chk("dut16_out", out16, e16.out);
                    chk("dut16_carry", {31'd0, cy16}, {31'd0, e16.carry});
                    chk("dut16_div_zero", {31'd0, dz16}, {31'd0, e16.dz});
                end
            end
        end
    end

    // Called 1ns after a posedge; returns 1ns after the accepting posedge.
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input bit expect_out, output int waited);
        logic [15:0] am, bm;
        am = sel ? a : (a & 16'h00FF);
        bm = sel ? b : (b & 16'h00FF);
        fun_d = op;
        a_d = a;
        b_d = b;
        in_valid = 1'b1;
        waited = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (ir) begin
                waited = i;
                if (expect_out) begin
                    if (sel) q16.push_back(model(16, op, {48'd0, am}, {48'd0, bm}));
                    else     q8.push_back(model(8, op, {48'd0, am}, {48'd0, bm}));
                end
                break;
            end
            @(posedge clk);
            #1;
        end
        if (waited == 0) fail("accept_timeout");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a_d = 16'($urandom);
        b_d = 16'($urandom);
        fun_d = 4'($urandom);
    endtask

    // Waits for OUT_VALID, checking latency and the directed result values.
    task automatic expect_result(input string name, input int lat, input logic [31:0] out,
                                 input logic c, input logic z, input bit busy_check);
        int n;
        n = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (ov) begin n = i; break; end
            if (busy_check) chk({name, "_in_ready_busy"}, {31'd0, ir}, 32'd0);
        end
        chk({name, "_latency"}, n, lat);
        chk({name, "_out"}, out_v, out);
        chk({name, "_carry"}, {31'd0, cy}, {31'd0, c});
        chk({name, "_div_zero"}, {31'd0, dz}, {31'd0, z});
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && (q8.size() != 0 || q16.size() != 0); i++) @(posedge clk);
        #1;
        chk({name, "_drained"}, q8.size() + q16.size(), 0);
    endtask

    // Absolute time bound.
    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    // Directed and random stimulus.
    initial begin
        int w;
        int pulses;
        logic [3:0] op;
        logic [15:0] ra, rb;

        rst_n = 1'b0; sel = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a_d = '0; b_d = '0; fun_d = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out8", {16'h0000, out8}, 32'd0);
        chk("reset_flags8", {29'd0, ov8, cy8, dz8}, 32'd0);
        chk("reset_ready8", {31'd0, ir8}, 32'd1);
        chk("reset_out16", out16, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADD and SUB with carry/borrow.
        issue(4'h0, 16'd200, 16'd100, 1'b1, w);
        expect_result("add", 1, 32'd300, 1'b1, 1'b0, 1'b0);
        issue(4'h1, 16'd5, 16'd9, 1'b1, w);
        expect_result("sub", 1, 32'h0000FFFC, 1'b1, 1'b0, 1'b0);

        // Reset while a division is in flight.
        issue(4'h3, 16'd200, 16'd7, 1'b0, w);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("div_abort_out", out_v, 32'd0);
        chk("div_abort_flags", {29'd0, ov, cy, dz}, 32'd0);
        chk("div_abort_ready", {31'd0, ir}, 32'd1);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ov) pulses++;
        end
        chk("div_abort_no_pulse", pulses, 0);
        @(posedge clk);
        #1;

        // Multi-cycle division and divide-by-zero.
        issue(4'h3, 16'd200, 16'd7, 1'b1, w);
        expect_result("div", 9, 32'h0000041C, 1'b0, 1'b0, 1'b1);
        issue(4'h3, 16'd55, 16'd0, 1'b1, w);
        expect_result("div0", 1, 32'h000037FF, 1'b0, 1'b1, 1'b0);
        issue(4'h4, 16'h00F0, 16'h003C, 1'b1, w);
        expect_result("and", 1, 32'h00000030, 1'b0, 1'b0, 1'b0);

        // Backpressure then back-to-back accept.
        out_ready = 1'b0;
        issue(4'h2, 16'd15, 16'd17, 1'b1, w);
        chk("mul_accept", w, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, ov}, 32'd1);
            chk("hold_out", out_v, 32'd255);
            chk("hold_ready", {31'd0, ir}, 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(4'hA, 16'd9, 16'd9, 1'b1, w);
        chk("b2b_accept", w, 1);
        expect_result("eq", 1, 32'd1, 1'b0, 1'b0, 1'b0);

        // Streaming single-cycle ops, then mixed ops including division, per width.
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            @(posedge clk);
            #1;
            for (int i = 0; i < 20; i++) begin
                op = 4'($urandom_range(0, 15));
                ra = 16'($urandom);
                rb = 16'($urandom);
                if (op == 4'h3) rb = 16'd0;
                if (i == 0) issue(op, ra, rb, 1'b1, w);
                else begin
                    issue(op, ra, rb, 1'b1, w);
                    chk("stream_rate", w, 1);
                end
            end
            drain("stream");
            for (int i = 0; i < 15; i++) begin
                op = 4'($urandom_range(0, 15));
                ra = 16'($urandom);
                rb = (i % 4 == 0) ? 16'($urandom_range(1, 5)) : 16'($urandom);
                if (i % 3 == 0) op = 4'h3;
                issue(op, ra, rb, 1'b1, w);
            end
            drain("mixed");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
